imem_loader: RTL and testbench

Boot-time program loader that writes a RISC-V program into the single-cycle core's instruction memory. It is the writer side of the instruction-memory interface the core fetches from. It accepts a byte stream over a valid/ready handshake, typically from a UART receiver, and assembles little-endian 32-bit words. It writes those words to consecutive word addresses starting at 0 and holds the core in reset until a complete, well-formed image has been written.

---
 rtl/imem_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a length-prefixed byte stream into
// little-endian 32-bit instruction words, writes them to instruction memory
// from word address 0 upward, and holds the core in reset until a complete,
// well-formed image is in place.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the load is declared done.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   // Upper bound on the word count, widened so a 16-bit length compares cleanly.
   localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

   state_t              state_q, state_d;
   logic [7:0]          len_lo_q, len_lo_d;
   logic [15:0]         len_q, len_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [23:0]         word_q, word_d;
   logic [15:0]         idx_q, idx_d;
   logic                in_ready_q, in_ready_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                core_rst_q, core_rst_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   logic                xfer;
   logic [15:0]         n_rx;
   state_t              after_last;

   assign xfer = in_valid && in_ready_q;
   assign n_rx = {in_data, len_lo_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign after_last = S_CSUM;
`else
   assign after_last = S_DONE;
`endif

   // Next-state logic: handshake-driven sequencing, word assembly and write strobe.
   always_comb begin
      state_d     = state_q;
      len_lo_d    = len_lo_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      idx_d       = idx_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN0;
               cnt_d   = 2'd0;
               idx_d   = 16'd0;
               word_d  = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end
         end
         S_LEN0: begin
            if (xfer) begin
               len_lo_d = in_data;
               state_d  = S_LEN1;
            end
         end
         S_LEN1: begin
            if (xfer) begin
               len_d = n_rx;
               if (n_rx == 16'd0 || {1'b0, n_rx} > MAX_W17) state_d = S_ERR;
               else                                         state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (cnt_q == 2'd3) begin
                  // Fourth byte completes the word: earlier bytes sit in word_q
                  // with the oldest byte at the bottom.
                  mem_we_d    = 1'b1;
                  mem_addr_d  = idx_q[ADDR_W-1:0];
                  mem_wdata_d = {in_data, word_q};
                  word_d      = 24'd0;
                  idx_d       = idx_q + 16'd1;
                  if (idx_q == len_q - 16'd1) state_d = after_last;
               end else begin
                  word_d = {in_data, word_q[23:8]};
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (xfer) begin
               if (in_data == csum_q) state_d = S_DONE;
               else                   state_d = S_ERR;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the upcoming state so they line up with it.
   always_comb begin
      in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state_d == S_CSUM) in_ready_d = 1'b1;
`endif
      core_rst_d = (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      error_d    = (state_d == S_ERR);
   end

   // State and output registers; reset aborts any load in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_lo_q    <= 8'd0;
         len_q       <= 16'd0;
         cnt_q       <= 2'd0;
         word_q      <= 24'd0;
         idx_q       <= 16'd0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         core_rst_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         len_lo_q    <= len_lo_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         core_rst_q  <= core_rst_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign core_rst  = core_rst_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven image loads plus hand-written
// sequences for the maximum-size image, mid-load reset and checksum cases.
module tb_imem_loader;

   localparam int ADDR_W    = 10;
   localparam int MAX_WORDS = 1024;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_rst;
   logic              done;
   logic              error;

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_rst(core_rst), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;

   // Expected writes: {addr, data}
   logic [41:0] sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb.size() == 0) begin
            vec++;
            miss++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
         end else begin
            logic [41:0] e;
            e = sb.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e[41:32]));
            chk("wr_data", mem_wdata, e[31:0]);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the handshake.
   task automatic send_byte(input logic [7:0] b, output bit ok);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (in_ready !== 1'b1) begin
         ok = 1'b0;
         vec++;
         miss++;
         $display("FAIL hs_timeout: got in_ready %b expected 1 within 20 cycles", in_ready);
         in_valid = 1'b0;
      end else begin
         ok = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_ready", 32'(in_ready), 32'd1);
      chk("start_done",     32'(done),     32'd0);
      chk("start_error",    32'(error),    32'd0);
      chk("start_core_rst", 32'(core_rst), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_wdata", mem_wdata,      32'd0);
      chk("rst_core_rst",  32'(core_rst),  32'd1);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_error",     32'(error),     32'd0);
   endtask

   task automatic chk_final(input bit exp_done, input bit exp_err);
      chk("fin_done",     32'(done),     32'(exp_done));
      chk("fin_error",    32'(error),    32'(exp_err));
      chk("fin_core_rst", 32'(core_rst), 32'(!exp_done));
      chk("fin_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic drain();
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   typedef struct packed {
      int          n;
      logic [95:0] b;
      bit          tog;
      bit          csum;
      bit          exp_done;
      bit          exp_err;
      int          nw;
      logic [63:0] w;
   } vec_t;

   vec_t tbl[5];

   initial begin
      bit          ok;
      logic [7:0]  x;
      logic [7:0]  bb;
      logic [31:0] wd;

      // Streams are written with byte 0 in the least-significant position.
      tbl[0] = '{10, 96'h00B0_0593_00A0_0513_0002, 1'b0, 1'b1, 1'b1, 1'b0, 2, 64'h00B00593_00A00513};
      tbl[1] = '{10, 96'h00B0_0593_00A0_0513_0002, 1'b1, 1'b1, 1'b1, 1'b0, 2, 64'h00B00593_00A00513};
      tbl[2] = '{2,  96'h0000,                      1'b0, 1'b0, 1'b0, 1'b1, 0, 64'h0};
      tbl[3] = '{6,  96'h00A0_0513_0001,           1'b0, 1'b1, 1'b1, 1'b0, 1, 64'h00A00513};
      tbl[4] = '{2,  96'h0401,                      1'b0, 1'b0, 1'b0, 1'b1, 0, 64'h0};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < tbl[i].nw; k++)
            sb.push_back({k[9:0], tbl[i].w[32*k +: 32]});
         pulse_start();
         ok = 1'b1;
         x  = 8'd0;
         for (int k = 0; k < tbl[i].n && ok; k++) begin
            bb = tbl[i].b[8*k +: 8];
            if (k >= 2) x = x ^ bb;
            send_byte(bb, ok);
            if (tbl[i].tog && k < tbl[i].n - 1) @(negedge clk);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (ok && tbl[i].csum) send_byte(x, ok);
`endif
         if (ok) chk_final(tbl[i].exp_done, tbl[i].exp_err);
         drain();
      end

      // Largest accepted image: MAX_WORDS words.
      pulse_start();
      send_byte(8'h00, ok);
      if (ok) send_byte(8'h04, ok);
      x = 8'd0;
      for (int wi = 0; wi < MAX_WORDS && ok; wi++) begin
         for (int k = 0; k < 4; k++) begin
            bb = 8'(wi * 7 + k * 61 + 3);
            wd[8*k +: 8] = bb;
         end
         sb.push_back({wi[9:0], wd});
         for (int k = 0; k < 4 && ok; k++) begin
            x = x ^ wd[8*k +: 8];
            send_byte(wd[8*k +: 8], ok);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (ok) send_byte(x, ok);
`endif
      if (ok) chk_final(1'b1, 1'b0);
      drain();

      // Reset after 5 data bytes: only word 0 reaches memory.
      sb.push_back({10'd0, 32'h00A00513});
      pulse_start();
      ok = 1'b1;
      wd = 32'h9300_0200;
      send_byte(8'h02, ok);
      if (ok) send_byte(8'h00, ok);
      if (ok) send_byte(8'h13, ok);
      if (ok) send_byte(8'h05, ok);
      if (ok) send_byte(8'hA0, ok);
      if (ok) send_byte(8'h00, ok);
      if (ok) send_byte(8'h93, ok);
      do_reset();
      drain();
      chk("post_rst_in_ready", 32'(in_ready), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum good then bad; the word is written either way.
      for (int t = 0; t < 2; t++) begin
         sb.push_back({10'd0, 32'h00A00513});
         pulse_start();
         ok = 1'b1;
         send_byte(8'h01, ok);
         if (ok) send_byte(8'h00, ok);
         if (ok) send_byte(8'h13, ok);
         if (ok) send_byte(8'h05, ok);
         if (ok) send_byte(8'hA0, ok);
         if (ok) send_byte(8'h00, ok);
         if (ok) send_byte((t == 0) ? 8'hB6 : 8'hB7, ok);
         if (ok) chk_final(t == 0, t == 1);
         drain();
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
